// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity mode constants and
// the default payload width. Intended for reuse by the matching receiver.
package uart_pkg;

  // Frame sequencing states, common to transmitter and receiver
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Parity mode selectors
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Default payload bits per frame
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit queue: small synchronous FIFO with a registered occupancy count.
// The head entry is read combinationally so the frame FSM can load it into
// its shift register on the same edge that pops it.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Guard both ports so an overflowing push or underflowing pop is ignored
  always_comb begin
    push_ok = push && (count_reg != FULL_COUNT);
    pop_ok  = pop && (count_reg != '0);
  end

  // Storage array; contents need no reset because the count gates reads
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queued bytes are serialised as start, LSB-first data,
// optional parity and one or two stop bits, advancing one bit per baud_tick.
// Back-to-back queued bytes are sent with no idle gap between frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         baud_tick,
  input  logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int             BW         = $clog2(DATA_BITS);
  localparam logic [BW-1:0]  LAST_BIT   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  BIT_ONE    = BW'(1);
  localparam logic           STOP_LAST  = (STOP_BITS == 2);
  localparam logic           HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic           ODD_PARITY = (PARITY_MODE == PARITY_ODD);

  uart_state_t          state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BW-1:0]        bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic                 parity_reg;
  logic                 tx_reg;

  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 last_stop;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (tx_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Pop the head only on a tick that starts a new frame: from IDLE, or at the
  // end of the final stop bit so the next start bit follows immediately
  always_comb begin
    push      = tx_valid && !fifo_full;
    last_stop = (stop_cnt_reg == STOP_LAST);
    pop       = baud_tick && !fifo_empty &&
                ((state_reg == IDLE) || ((state_reg == STOP) && last_stop));
  end

  // Frame FSM; tx is registered so the line moves one clk after each tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else if (baud_tick) begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg  <= fifo_head;
            parity_reg <= (^fifo_head) ^ ODD_PARITY;
            tx_reg     <= 1'b0;
            state_reg  <= START;
          end
        end
        START: begin
          tx_reg      <= shift_reg[0];
          shift_reg   <= shift_reg >> 1;
          bit_cnt_reg <= '0;
          state_reg   <= DATA;
        end
        DATA: begin
          if (bit_cnt_reg == LAST_BIT) begin
            if (HAS_PARITY) begin
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
            end else begin
              tx_reg       <= 1'b1;
              stop_cnt_reg <= 1'b0;
              state_reg    <= STOP;
            end
          end else begin
            tx_reg      <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
          end
        end
        PARITY: begin
          tx_reg       <= 1'b1;
          stop_cnt_reg <= 1'b0;
          state_reg    <= STOP;
        end
        STOP: begin
          if (last_stop) begin
            if (pop) begin
              shift_reg  <= fifo_head;
              parity_reg <= (^fifo_head) ^ ODD_PARITY;
              tx_reg     <= 1'b0;
              state_reg  <= START;
            end else begin
              tx_reg    <= 1'b1;
              state_reg <= IDLE;
            end
          end else begin
            stop_cnt_reg <= 1'b1;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = !fifo_full;
  assign busy     = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) share clock, reset
// and baud_tick. A queue-based line model predicts tx, fifo_count, tx_ready
// and busy every cycle; a vector table and hand sequences cover the corners.
module tb_uart_tx;

  localparam int NI    = 4;
  localparam int DEPTH = 4;
  localparam int PM [NI] = '{0, 1, 2, 0};
  localparam int SB [NI] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud_tick = 1'b0;
  logic [NI-1:0][7:0] data_v;
  logic [NI-1:0]      valid_v;
  logic [NI-1:0]      ready_v;
  logic [NI-1:0]      tx_v;
  logic [NI-1:0]      busy_v;
  logic [NI-1:0][2:0] cnt_v;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    uart_tx #(
      .DATA_BITS   (8),
      .PARITY_MODE (PM[gi]),
      .STOP_BITS   (SB[gi]),
      .FIFO_DEPTH  (DEPTH)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .baud_tick  (baud_tick),
      .tx_data    (data_v[gi]),
      .tx_valid   (valid_v[gi]),
      .tx_ready   (ready_v[gi]),
      .tx         (tx_v[gi]),
      .busy       (busy_v[gi]),
      .fifo_count (cnt_v[gi])
    );
  end

  // Reference model: pending bytes and the remaining bits of the current frame
  logic [7:0] pend_q [NI][$];
  bit         cur_q  [NI][$];
  bit         m_line   [NI];
  bit         m_active [NI];
  bit         m_acc    [NI];
  int         n_tests;
  int         n_fail;

  typedef struct {
    int          inst;
    logic [7:0]  data;
    logic [15:0] exp;
    int          nbits;
  } vec_t;

  // Bit k of the result is the k-th bit on the line for one frame
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int pm,
                                             input int sb, output int n);
    logic [15:0] v;
    v = '1;
    n = 0;
    v[n] = 1'b0; n++;
    for (int k = 0; k < 8; k++) begin v[n] = d[k]; n++; end
    if (pm != 0) begin
      v[n] = (($countones(d) % 2) == 1) ^ (pm == 2);
      n++;
    end
    for (int s = 0; s < sb; s++) begin v[n] = 1'b1; n++; end
    return v;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      pend_q[i].delete();
      cur_q[i].delete();
      m_line[i]   = 1'b1;
      m_active[i] = 1'b0;
      m_acc[i]    = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input bit tick);
    bit acc;
    logic [15:0] fv;
    int n;
    acc = valid_v[i] && (pend_q[i].size() < DEPTH);
    m_acc[i] = acc;
    if (tick) begin
      if (cur_q[i].size() == 0 && pend_q[i].size() != 0) begin
        fv = frame_bits(pend_q[i].pop_front(), PM[i], SB[i], n);
        for (int k = 0; k < n; k++) cur_q[i].push_back(fv[k]);
      end
      if (cur_q[i].size() != 0) begin
        m_line[i]   = cur_q[i].pop_front();
        m_active[i] = 1'b1;
      end else begin
        m_line[i]   = 1'b1;
        m_active[i] = 1'b0;
      end
    end
    if (acc) pend_q[i].push_back(data_v[i]);
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check("tx", i, 32'(tx_v[i]), 32'(m_line[i]));
      check("fifo_count", i, 32'(cnt_v[i]), 32'(pend_q[i].size()));
      check("tx_ready", i, 32'(ready_v[i]), 32'(pend_q[i].size() < DEPTH));
      check("busy", i, 32'(busy_v[i]), 32'(m_active[i] || pend_q[i].size() != 0));
    end
  endtask

  // One clock: apply tick, advance the model at the edge, compare 1 time unit later
  task automatic cycle(input bit tick);
    baud_tick = tick;
    @(posedge clk);
    if (reset) model_reset();
    else for (int i = 0; i < NI; i++) model_edge(i, tick);
    #1;
    compare_all();
  endtask

  initial begin
    vec_t tbl [6];
    logic [15:0] cap;
    logic [31:0] cap2;
    logic [31:0] exp2;
    logic [15:0] fv;
    int n1;
    int n2;
    int sent;
    int idx;

    n_tests = 0;
    n_fail  = 0;
    valid_v = '0;
    data_v  = '0;
    model_reset();

    // Reset state
    repeat (3) cycle(1'b0);
    for (int i = 0; i < NI; i++) begin
      check("reset_tx", i, 32'(tx_v[i]), 32'd1);
      check("reset_count", i, 32'(cnt_v[i]), 32'd0);
      check("reset_busy", i, 32'(busy_v[i]), 32'd0);
      check("reset_ready", i, 32'(ready_v[i]), 32'd1);
    end
    reset = 1'b0;
    repeat (2) cycle(1'b0);

    // Single frames, tick every 16 clks; last captured bit is the idle line
    tbl[0] = '{0, 8'h55, 16'b00000_11010101010, 11};
    tbl[1] = '{1, 8'h07, 16'b0000_111000001110, 12};
    tbl[2] = '{2, 8'h00, 16'b0000_111000000000, 12};
    tbl[3] = '{3, 8'hFF, 16'b0000_111111111110, 12};
    tbl[4] = '{0, 8'hA5, 16'b00000_11101001010, 11};
    tbl[5] = '{1, 8'h03, 16'b0000_110000000110, 12};
    for (int v = 0; v < 6; v++) begin
      valid_v[tbl[v].inst] = 1'b1;
      data_v[tbl[v].inst]  = tbl[v].data;
      cycle(1'b0);
      valid_v[tbl[v].inst] = 1'b0;
      cap = '0;
      for (int k = 0; k < tbl[v].nbits; k++) begin
        repeat (15) cycle(1'b0);
        cycle(1'b1);
        cap[k] = tx_v[tbl[v].inst];
      end
      check("frame_bits", tbl[v].inst, 32'(cap), 32'(tbl[v].exp));
      check("busy_after_stop", tbl[v].inst, 32'(busy_v[tbl[v].inst]), 32'd0);
      $display("[TB] vector %0d inst%0d data %02h line %04h", v, tbl[v].inst, tbl[v].data, cap);
    end

    // Stall with baud_tick low: four accepted, fifth held until a pop frees a slot
    sent = 0;
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h10;
    repeat (8) begin
      cycle(1'b0);
      if (m_acc[0] && sent < 4) begin
        sent++;
        data_v[0] = 8'h10 + 8'(sent);
      end
    end
    check("stall_count", 0, 32'(cnt_v[0]), 32'd4);
    check("stall_ready", 0, 32'(ready_v[0]), 32'd0);
    cycle(1'b1);
    check("stall_after_pop_count", 0, 32'(cnt_v[0]), 32'd3);
    check("stall_after_pop_ready", 0, 32'(ready_v[0]), 32'd1);
    cycle(1'b0);
    check("stall_fifth_accepted", 0, 32'(cnt_v[0]), 32'd4);
    valid_v[0] = 1'b0;
    repeat (60) cycle(1'b1);
    check("stall_drained_busy", 0, 32'(busy_v[0]), 32'd0);
    $display("[TB] stall sequence: 5 bytes through a 4-entry queue");

    // Back-to-back frames: 0xA5 then 0x3C, 20 contiguous bit periods
    valid_v[0] = 1'b1;
    data_v[0]  = 8'hA5;
    cycle(1'b0);
    data_v[0]  = 8'h3C;
    cycle(1'b0);
    valid_v[0] = 1'b0;
    cap2 = '1;
    for (int k = 0; k < 21; k++) begin
      repeat (3) cycle(1'b0);
      cycle(1'b1);
      cap2[k] = tx_v[0];
    end
    exp2 = '1;
    fv = frame_bits(8'hA5, 0, 1, n1);
    for (int k = 0; k < n1; k++) exp2[k] = fv[k];
    fv = frame_bits(8'h3C, 0, 1, n2);
    for (int k = 0; k < n2; k++) exp2[n1 + k] = fv[k];
    check("back_to_back", 0, cap2, exp2);
    $display("[TB] back-to-back A5,3C line %06h", cap2[20:0]);

    // Reset during data bit 3 with two bytes still queued
    valid_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_v[0] = (k == 0) ? 8'hF0 : 8'(8'h11 * k);
      cycle(1'b0);
    end
    valid_v[0] = 1'b0;
    repeat (5) begin
      cycle(1'b0);
      cycle(1'b1);
    end
    check("pre_reset_bit3", 0, 32'(tx_v[0]), 32'd0);
    check("pre_reset_count", 0, 32'(cnt_v[0]), 32'd2);
    #4;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_tx", 0, 32'(tx_v[0]), 32'd1);
    check("async_reset_count", 0, 32'(cnt_v[0]), 32'd0);
    check("async_reset_busy", 0, 32'(busy_v[0]), 32'd0);
    check("async_reset_ready", 0, 32'(ready_v[0]), 32'd1);
    cycle(1'b1);
    reset = 1'b0;
    repeat (40) cycle(1'b1);
    check("post_reset_idle", 0, 32'(tx_v[0]), 32'd1);
    $display("[TB] mid-frame reset sequence");

    // Two stop bits: next start bit 11 ticks after the first start bit
    valid_v[3] = 1'b1;
    data_v[3]  = 8'hFF;
    cycle(1'b0);
    data_v[3]  = 8'h00;
    cycle(1'b0);
    valid_v[3] = 1'b0;
    cap2 = '1;
    for (int k = 0; k < 23; k++) begin
      cycle(1'b0);
      cycle(1'b1);
      cap2[k] = tx_v[3];
    end
    idx = -1;
    for (int k = 22; k >= 1; k--) if (cap2[k] == 1'b0) idx = k;
    check("stop2_first_start", 3, 32'(cap2[0]), 32'd0);
    check("stop2_ones", 3, 32'(cap2[10:1]), 32'h3FF);
    check("stop2_next_start", 3, 32'(idx), 32'd11);
    repeat (30) cycle(1'b1);
    $display("[TB] two-stop sequence next start at tick %0d", idx);

    // Randomised traffic on all instances, with stalls held stable
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (!valid_v[i] || m_acc[i]) begin
          valid_v[i] = ($urandom_range(0, 2) == 0);
          data_v[i]  = 8'($urandom);
        end
      end
      cycle((c % 500) < 100 ? 1'b1 : ($urandom_range(0, 3) == 0));
    end
    valid_v = '0;
    repeat (200) cycle(1'b1);
    for (int i = 0; i < NI; i++) check("final_idle_busy", i, 32'(busy_v[i]), 32'd0);
    $display("[TB] random traffic phase complete");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, payload bits per frame (5..9).
REQ-002 SHALL have parameter PARITY_MODE, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit queue entries (power of 2, at least 2).
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port baud_tick  input  1  one-clk-wide strobe, one per bit period, from the baud rate generator stage.
REQ-008 SHALL have port tx_data  input  DATA_BITS  byte to send.
REQ-009 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-010 SHALL have port tx_ready  output  1  queue can accept a byte.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress or queue non-empty.
REQ-013 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  queued bytes.

Function
REQ-014 SHALL accept a byte on a rising clk when tx_valid and tx_ready are both high; tx_ready = queue not full.
REQ-015 SHALL hold tx_valid-without-tx_ready as a stall: no write, no data loss, no error flag.
REQ-016 SHALL leave fifo_count unchanged on simultaneous push and pop; push when full is impossible by handshake; pop never occurs when empty.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; every state transition occurs only on a cycle with baud_tick high.
REQ-018 IDLE: tx=1; on baud_tick with queue non-empty, SHALL pop the head into the shift register and enter START.
REQ-019 START: tx=0 for one bit period, then DATA.
REQ-020 DATA: SHALL send LSB first, one bit per period, for DATA_BITS periods; then PARITY if PARITY_MODE!=0, else STOP.
REQ-021 PARITY: tx = XOR of data bits (even) or its inverse (odd), for one period.
REQ-022 STOP: tx=1 for STOP_BITS periods; on the final stop tick, SHALL pop and go directly to START if the queue is non-empty (no idle gap), else go to IDLE.
REQ-023 tx SHALL be driven from a register; the line changes one clk after the qualifying baud_tick.
REQ-024 Latency: with the block idle and the queue empty, the start bit SHALL appear one clk after the first baud_tick occurring after the write clock edge.
REQ-025 busy SHALL equal (state != IDLE) OR (fifo_count != 0).
REQ-026 SHALL treat baud_tick high on consecutive clocks as separate bit periods; no minimum spacing is checked.

Reset
REQ-027 While reset is high: tx=1, state IDLE, queue empty, fifo_count=0, busy=0, tx_ready=1.
REQ-028 Reset asserted mid-frame SHALL force tx high immediately (asynchronously), abort the frame and discard all queued bytes.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state encodings, the PARITY_MODE constants and the default DATA_BITS, for reuse by the future uart_rx.
REQ-030 The queue SHALL be a separate sub-module uart_tx_fifo (synchronous, registered count, same clk/reset), with the frame FSM in uart_tx.

Verification
REQ-031 0x55, 8N1, tick every 16 clks -> tx sequence 0,1,0,1,0,1,0,1,0,1 on successive ticks, then idle high; busy falls after the stop bit.
REQ-032 PARITY_MODE=1, 0x07 -> parity bit 1; PARITY_MODE=2, 0x00 -> parity bit 1; frame is 11 bits.
REQ-033 baud_tick held low, push 5 bytes -> first 4 accepted, fifo_count=4, tx_ready=0, 5th stalled; after the first tick, 5th accepted.
REQ-034 0xA5 then 0x3C queued, 8N1 -> 20 contiguous bit periods, stop of frame 1 directly followed by start of frame 2.
REQ-035 Reset asserted in DATA bit 3 of a frame with 2 bytes queued -> tx=1 the same cycle, fifo_count=0, busy=0; no further bits after release.
REQ-036 STOP_BITS=2, 0xFF -> start 0, eight 1s, two stop 1s; the next frame's start bit begins at the 11th tick after the first start bit.
